// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the register file and its scoreboard.
//   REG_ZERO      : architectural hard-wired zero register index
//   DATA_W_DEF    : default register width
//   ADDR_W_DEF    : default register address width
//   reg_addr_t    : 5-bit register index
//   word_t        : 32-bit data word
package cpu_defs;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// Holds one busy bit per register, applies set/clear with "set wins" priority,
// and raises stall when a source operand is busy and not covered by a
// same-cycle write-back.
//   clk, rst               : clock, synchronous active-high reset
//   ra_a, ra_b             : source register indices being read
//   we, wa                 : write-back enable / destination
//   iss_valid, iss_pend    : issuing instruction, and whether it is long-latency
//   iss_dst                : destination of the issuing instruction
//   stall                  : a source operand is pending; issue must hold
module rf_scoreboard
  import cpu_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              iss_valid,
  input  logic              iss_pend,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             set_en;
  logic             clr_en;
  logic             hit_a;
  logic             hit_b;

  // A stalled issue is re-presented next cycle, so it must not mark anything.
  assign set_en = iss_valid && iss_pend && (iss_dst != ZERO_IDX) && !stall;
  assign clr_en = we && (wa != ZERO_IDX);

  // Set after clear: a new producer claiming the register in the same cycle
  // an older result lands keeps it busy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign set_vec[gi]   = set_en && (iss_dst == ADDR_W'(gi));
    assign clr_vec[gi]   = clr_en && (wa == ADDR_W'(gi));
    assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Forwarded write data satisfies the operand, so only hide the hazard
  // when bypass is present.
  assign hit_a = (BYPASS != 0) && we && (wa == ra_a);
  assign hit_b = (BYPASS != 0) && we && (wa == ra_b);

  assign stall = (busy_reg[ra_a] && (ra_a != ZERO_IDX) && !hit_a) ||
                 (busy_reg[ra_b] && (ra_b != ZERO_IDX) && !hit_b);

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with write-back port, two combinational read
// ports with optional write-to-read bypass, and a load scoreboard.
//   clk, rst        : clock, synchronous active-high reset
//   ra_a/rd_a       : read port A address / data
//   ra_b/rd_b       : read port B address / data
//   we, wa, wd      : write-back enable, address, data
//   iss_valid/iss_pend/iss_dst : issue interface for the scoreboard
//   stall           : source operand pending
module reg_file_wb
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic              iss_pend,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wr_en;

  assign wr_en = we && (wa != ZERO_IDX);

  // One register per entry so reset can clear the whole file in one edge.
  // Entry 0 is never written; reads of R0 are forced to zero below anyway.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wa == ADDR_W'(gi))) begin
        mem_reg[gi] <= wd;
      end
    end
  end

  always_comb begin
    rd_a = mem_reg[ra_a];
    rd_b = mem_reg[ra_b];
    if ((BYPASS != 0) && wr_en && (wa == ra_a)) rd_a = wd;
    if ((BYPASS != 0) && wr_en && (wa == ra_b)) rd_b = wd;
    if (ra_a == ZERO_IDX) rd_a = '0;
    if (ra_b == ZERO_IDX) rd_b = '0;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .ra_a      (ra_a),
    .ra_b      (ra_b),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_pend  (iss_pend),
    .iss_dst   (iss_dst),
    .stall     (stall)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra_a, ra_b, wa, iss_dst;
  logic [31:0] rd_a, rd_b, wd;
  logic        we, iss_valid, iss_pend, stall;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents and which registers await a load.
  logic [31:0] model_mem  [32];
  bit          model_busy [32];

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk       (clk),
    .rst       (rst),
    .ra_a      (ra_a),
    .ra_b      (ra_b),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_pend  (iss_pend),
    .iss_dst   (iss_dst),
    .stall     (stall)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return model_mem[ra];
  endfunction

  function automatic bit src_waiting(input logic [4:0] ra);
    return ra != 5'd0 && model_busy[ra] && !(we && wa == ra);
  endfunction

  function automatic logic exp_stall();
    return src_waiting(ra_a) || src_waiting(ra_b);
  endfunction

  task automatic idle();
    rst = 0; ra_a = 0; ra_b = 0; we = 0; wa = 0; wd = 0;
    iss_valid = 0; iss_pend = 0; iss_dst = 0;
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    logic st;
    st = exp_stall();
    $display("t=%0t rst=%0d ra_a=%0d rd_a=%h ra_b=%0d rd_b=%h we=%0d wa=%0d wd=%h iss=%0d/%0d/%0d stall=%0d",
             $time, rst, ra_a, rd_a, ra_b, rd_b, we, wa, wd, iss_valid, iss_pend, iss_dst, stall);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        model_mem[i] = 0;
        model_busy[i] = 0;
      end
    end else begin
      if (we && wa != 0) begin
        model_mem[wa] = wd;
        model_busy[wa] = 0;
      end
      if (iss_valid && iss_pend && iss_dst != 0 && !st) model_busy[iss_dst] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick();
    rst = 0; ra_a = 5; ra_b = 31; #2;
    checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL reset_rd_a got=%h exp=0", rd_a); end
    checks++; if (rd_b !== 32'd0) begin errors++; $display("FAIL reset_rd_b got=%h exp=0", rd_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); we = 1; wa = 8; wd = 32'hDEADBEEF; ra_a = 8; #2;
    checks++; if (rd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same got=%h exp=deadbeef", rd_a); end
    tick();
    we = 0; #2;
    checks++; if (rd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_after got=%h exp=deadbeef", rd_a); end
    tick();
  endtask

  task automatic test_r0();
    idle(); we = 1; wa = 0; wd = 32'hFFFFFFFF; ra_a = 0; ra_b = 0; #2;
    checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL r0_same got=%h exp=0", rd_a); end
    tick();
    we = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL r0_later got=%h exp=0", rd_a); end
      tick();
    end
  endtask

  task automatic test_load_stall();
    idle(); iss_valid = 1; iss_pend = 1; iss_dst = 9; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_issue_stall got=%b exp=0", stall); end
    tick();
    idle(); ra_b = 9;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_wait_stall cyc=%0d got=%b exp=1", i, stall); end
      tick();
    end
    we = 1; wa = 9; wd = 32'd7; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_wb_stall got=%b exp=0", stall); end
    checks++; if (rd_b !== 32'd7) begin errors++; $display("FAIL load_wb_rd_b got=%h exp=7", rd_b); end
    tick();
    we = 0; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_done_stall got=%b exp=0", stall); end
    checks++; if (rd_b !== 32'd7) begin errors++; $display("FAIL load_done_rd_b got=%h exp=7", rd_b); end
    tick();
  endtask

  task automatic test_set_wins();
    idle(); iss_valid = 1; iss_pend = 1; iss_dst = 4; we = 1; wa = 4; wd = 32'h55; tick();
    idle(); ra_a = 4; #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL set_wins_stall got=%b exp=1", stall); end
    checks++; if (rd_a !== 32'h55) begin errors++; $display("FAIL set_wins_rd_a got=%h exp=55", rd_a); end
    tick();
    // A stalled issue must not mark its destination.
    idle(); ra_a = 4; iss_valid = 1; iss_pend = 1; iss_dst = 11; tick();
    idle(); ra_a = 11; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stalled_issue_set got=%b exp=0", stall); end
    tick();
    idle(); we = 1; wa = 4; wd = 32'h66; tick();
    idle(); ra_a = 4; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clear_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_reset_midop();
    idle(); iss_valid = 1; iss_pend = 1; iss_dst = 3; tick();
    idle(); ra_a = 3; #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midop_busy got=%b exp=1", stall); end
    rst = 1; tick();
    rst = 0; #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midop_stall got=%b exp=0", stall); end
    for (int i = 0; i < 32; i++) begin
      ra_a = 5'(i); ra_b = 5'(31 - i); #1;
      checks++; if (rd_a !== 32'd0 || rd_b !== 32'd0) begin
        errors++; $display("FAIL midop_clear reg=%0d got=%h/%h exp=0/0", i, rd_a, rd_b);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      rst       = ($urandom_range(0, 59) == 0);
      ra_a      = 5'($urandom_range(0, 7));
      ra_b      = 5'($urandom_range(0, 7));
      we        = ($urandom_range(0, 2) == 0);
      wa        = 5'($urandom_range(0, 7));
      wd        = $urandom;
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_pend  = ($urandom_range(0, 1) == 0);
      iss_dst   = 5'($urandom_range(0, 7));
      #2;
      checks++; if (rd_a !== exp_rd(ra_a)) begin errors++; $display("FAIL rand_rd_a n=%0d got=%h exp=%h", n, rd_a, exp_rd(ra_a)); end
      checks++; if (rd_b !== exp_rd(ra_b)) begin errors++; $display("FAIL rand_rd_b n=%0d got=%h exp=%h", n, rd_b, exp_rd(ra_b)); end
      checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, exp_stall()); end
      tick();
    end
  endtask

  initial begin
    idle(); rst = 1;
    @(posedge clk); #1;
    tick();
    test_reset();
    test_bypass();
    test_r0();
    test_load_stall();
    test_set_wins();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
